// File: rtl/qa_sample_source_pkg.sv
// Shared types and defaults for the QA sample source.
// Optional multi-pass playback is enabled by defining QA_SAMPLE_SOURCE_LOOP_EN.
package qa_sample_source_pkg;

  localparam int unsigned WIDTH_DEF = 32;
  localparam int unsigned DEPTH_DEF = 64;
  localparam int unsigned GAP_W_DEF = 8;

  // Playback FSM states
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PLAY = 2'd1,
    ST_GAP  = 2'd2
  } state_e;

endpackage

// File: rtl/qa_sample_source_mem.sv
// Sample buffer: DEPTH x WIDTH register array, synchronous write, asynchronous read.
// Ports:
//   clk       write clock
//   i_wr_en   write strobe
//   i_wr_addr write address
//   i_wr_data write data
//   i_rd_addr read address
//   o_rd_data combinational read data
module qa_sample_source_mem
  import qa_sample_source_pkg::*;
#(
  parameter int unsigned WIDTH  = WIDTH_DEF,
  parameter int unsigned DEPTH  = DEPTH_DEF,
  parameter int unsigned ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              i_wr_en,
  input  logic [ADDR_W-1:0] i_wr_addr,
  input  logic [WIDTH-1:0]  i_wr_data,
  input  logic [ADDR_W-1:0] i_rd_addr,
  output logic [WIDTH-1:0]  o_rd_data
);

  logic [WIDTH-1:0] r_mem [DEPTH];

  // Contents are not reset; playback only ever reads entries below count
  always_ff @(posedge clk) begin
    if (i_wr_en) r_mem[i_wr_addr] <= i_wr_data;
  end

  assign o_rd_data = r_mem[i_rd_addr];

endmodule

// File: rtl/qa_sample_source.sv
// QA sample source: host loads samples into a buffer, start replays them as
// out_data/out_nd with a programmable idle gap between samples. No backpressure.
// Define QA_SAMPLE_SOURCE_LOOP_EN to add n_loops (buffer is played n_loops+1 times).
// Ports:
//   clk, rst_n            clock, async active-low reset
//   ld_data, ld_nd        sample load path (accepted in IDLE only)
//   clear                 empty buffer, clear overflow, abort playback
//   start, gap            begin playback, inter-sample idle cycles (latched at start)
//   n_loops               extra passes (LOOP_EN builds only, latched at start)
//   out_data, out_nd      played sample stream
//   busy, done            playback active, pulse with final sample
//   overflow, count       sticky load-when-full flag, stored sample count
module qa_sample_source
  import qa_sample_source_pkg::*;
#(
  parameter int unsigned WIDTH  = WIDTH_DEF,
  parameter int unsigned DEPTH  = DEPTH_DEF,
  parameter int unsigned ADDR_W = $clog2(DEPTH),
  parameter int unsigned GAP_W  = GAP_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [WIDTH-1:0]  ld_data,
  input  logic              ld_nd,
  input  logic              clear,
  input  logic              start,
  input  logic [GAP_W-1:0]  gap,
`ifdef QA_SAMPLE_SOURCE_LOOP_EN
  input  logic [7:0]        n_loops,
`endif
  output logic [WIDTH-1:0]  out_data,
  output logic              out_nd,
  output logic              busy,
  output logic              done,
  output logic              overflow,
  output logic [ADDR_W:0]   count
);

  localparam int unsigned CNT_W = ADDR_W + 1;

  state_e            r_state;
  logic [ADDR_W-1:0] r_rd_ptr;   // index of the sample currently (or last) presented
  logic [GAP_W-1:0]  r_gap_q;
  logic [GAP_W-1:0]  r_gap_cnt;
`ifdef QA_SAMPLE_SOURCE_LOOP_EN
  logic [7:0]        r_loops_left;
  logic [7:0]        w_loops_after;
`endif

  logic              w_full;
  logic              w_start_play;
  logic              w_load;
  logic              w_end_of_pass;
  logic              w_final;
  logic              w_next_final;
  logic              w_start_last;
  logic [ADDR_W-1:0] w_next_ptr;
  logic [ADDR_W-1:0] w_rd_addr;
  logic [WIDTH-1:0]  w_rd_data;

  assign w_full        = (count == CNT_W'(DEPTH));
  assign w_start_play  = start && (count != '0);
  // A start that begins playback takes the cycle; a coincident load is dropped
  assign w_load        = (r_state == ST_IDLE) && ld_nd && !clear && !w_start_play;
  assign w_end_of_pass = ({1'b0, r_rd_ptr} + CNT_W'(1)) == count;
  assign w_next_ptr    = w_end_of_pass ? '0 : r_rd_ptr + ADDR_W'(1);

`ifdef QA_SAMPLE_SOURCE_LOOP_EN
  assign w_loops_after = w_end_of_pass ? r_loops_left - 8'(1) : r_loops_left;
  assign w_final       = w_end_of_pass && (r_loops_left == '0);
  assign w_next_final  = (({1'b0, w_next_ptr} + CNT_W'(1)) == count) && (w_loops_after == '0);
  assign w_start_last  = (count == CNT_W'(1)) && (n_loops == '0);
`else
  assign w_final       = w_end_of_pass;
  assign w_next_final  = ({1'b0, w_next_ptr} + CNT_W'(1)) == count;
  assign w_start_last  = (count == CNT_W'(1));
`endif

  // IDLE always presents sample 0; PLAY/GAP look ahead to the next sample
  assign w_rd_addr = (r_state == ST_IDLE) ? '0 : w_next_ptr;

  qa_sample_source_mem #(
    .WIDTH  (WIDTH),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_mem (
    .clk       (clk),
    .i_wr_en   (w_load && !w_full),
    .i_wr_addr (count[ADDR_W-1:0]),
    .i_wr_data (ld_data),
    .i_rd_addr (w_rd_addr),
    .o_rd_data (w_rd_data)
  );

  // Playback FSM, counters and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_rd_ptr  <= '0;
      r_gap_q   <= '0;
      r_gap_cnt <= '0;
`ifdef QA_SAMPLE_SOURCE_LOOP_EN
      r_loops_left <= '0;
`endif
      out_data  <= '0;
      out_nd    <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      overflow  <= 1'b0;
      count     <= '0;
    end else begin
      done <= 1'b0;
      if (clear) begin
        r_state  <= ST_IDLE;
        out_nd   <= 1'b0;
        busy     <= 1'b0;
        overflow <= 1'b0;
        count    <= '0;
      end else begin
        case (r_state)
          ST_IDLE: begin
            if (w_start_play) begin
              r_state  <= ST_PLAY;
              r_rd_ptr <= '0;
              r_gap_q  <= gap;
`ifdef QA_SAMPLE_SOURCE_LOOP_EN
              r_loops_left <= n_loops;
`endif
              out_data <= w_rd_data;
              out_nd   <= 1'b1;
              busy     <= 1'b1;
              done     <= w_start_last;
            end else if (start) begin
              done <= 1'b1;
            end
            if (w_load) begin
              if (w_full) overflow <= 1'b1;
              else        count    <= count + CNT_W'(1);
            end
          end
          ST_PLAY: begin
            if (w_final) begin
              r_state <= ST_IDLE;
              out_nd  <= 1'b0;
              busy    <= 1'b0;
            end else if (r_gap_q != '0) begin
              r_state   <= ST_GAP;
              r_gap_cnt <= r_gap_q - GAP_W'(1);
              out_nd    <= 1'b0;
            end else begin
              r_rd_ptr <= w_next_ptr;
`ifdef QA_SAMPLE_SOURCE_LOOP_EN
              r_loops_left <= w_loops_after;
`endif
              out_data <= w_rd_data;
              out_nd   <= 1'b1;
              done     <= w_next_final;
            end
          end
          ST_GAP: begin
            if (r_gap_cnt == '0) begin
              r_state  <= ST_PLAY;
              r_rd_ptr <= w_next_ptr;
`ifdef QA_SAMPLE_SOURCE_LOOP_EN
              r_loops_left <= w_loops_after;
`endif
              out_data <= w_rd_data;
              out_nd   <= 1'b1;
              done     <= w_next_final;
            end else begin
              r_gap_cnt <= r_gap_cnt - GAP_W'(1);
            end
          end
          default: begin
            r_state <= ST_IDLE;
            out_nd  <= 1'b0;
            busy    <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_qa_sample_source.sv
// Scoreboard bench for qa_sample_source: stimulus pushes expected samples,
// a negedge monitor pops and compares whenever out_nd or done is seen.
module tb_qa_sample_source;

  localparam int unsigned WIDTH  = 32;
  localparam int unsigned DEPTH  = 64;
  localparam int unsigned ADDR_W = 6;
  localparam int unsigned GAP_W  = 8;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [WIDTH-1:0]  ld_data;
  logic              ld_nd;
  logic              clear;
  logic              start;
  logic [GAP_W-1:0]  gap;
`ifdef QA_SAMPLE_SOURCE_LOOP_EN
  logic [7:0]        n_loops;
`endif
  logic [WIDTH-1:0]  out_data;
  logic              out_nd;
  logic              busy;
  logic              done;
  logic              overflow;
  logic [ADDR_W:0]   count;

  qa_sample_source #(
    .WIDTH  (WIDTH),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W),
    .GAP_W  (GAP_W)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .ld_data  (ld_data),
    .ld_nd    (ld_nd),
    .clear    (clear),
    .start    (start),
    .gap      (gap),
`ifdef QA_SAMPLE_SOURCE_LOOP_EN
    .n_loops  (n_loops),
`endif
    .out_data (out_data),
    .out_nd   (out_nd),
    .busy     (busy),
    .done     (done),
    .overflow (overflow),
    .count    (count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic             nd;
    logic [WIDTH-1:0] data;
    logic             dn;
  } exp_t;

  exp_t exp_q[$];
  int   nd_stamps[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;
  int   busy_cycles = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: compare every presented sample / done pulse against the scoreboard
  always @(negedge clk) begin
    if (rst_n) begin
      if (busy) busy_cycles++;
      if (out_nd || done) begin
        if (out_nd) nd_stamps.push_back(cyc);
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_output: got nd=%0b data=%0h done=%0b expected nothing", out_nd, out_data, done);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("out_nd", 64'(out_nd), 64'(e.nd));
          if (e.nd) check("out_data", 64'(out_data), 64'(e.data));
          check("done", 64'(done), 64'(e.dn));
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_seq(input int n);
    for (int i = 0; i < n; i++) begin
      ld_data = WIDTH'(i + 1);
      ld_nd   = 1'b1;
      tick();
    end
    ld_nd = 1'b0;
  endtask

  task automatic push_seq(input int n);
    exp_t e;
    for (int i = 0; i < n; i++) begin
      e.nd = 1'b1; e.data = WIDTH'(i + 1); e.dn = (i == n - 1);
      exp_q.push_back(e);
    end
  endtask

  task automatic pulse_clear();
    clear = 1'b1;
    tick();
    clear = 1'b0;
  endtask

  task automatic do_start(input int g);
    nd_stamps.delete();
    busy_cycles = 0;
    gap   = GAP_W'(g);
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_drain(input int budget);
    int k = 0;
    while ((exp_q.size() != 0 || busy) && k < budget) begin
      tick();
      k++;
    end
    if (k >= budget) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain_timeout: got %0d pending expected 0", exp_q.size());
    end
    tick();
  endtask

  task automatic check_spacing(input int exp_n, input int exp_diff);
    check("pulse_count", 64'(nd_stamps.size()), 64'(exp_n));
    for (int i = 1; i < nd_stamps.size(); i++)
      check("pulse_spacing", 64'(nd_stamps[i] - nd_stamps[i-1]), 64'(exp_diff));
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_out_nd"},   64'(out_nd),   64'd0);
    check({tag, "_out_data"}, 64'(out_data), 64'd0);
    check({tag, "_busy"},     64'(busy),     64'd0);
    check({tag, "_done"},     64'(done),     64'd0);
    check({tag, "_overflow"}, 64'(overflow), 64'd0);
    check({tag, "_count"},    64'(count),    64'd0);
  endtask

  initial begin
    exp_t e;
    rst_n = 1'b0; ld_data = '0; ld_nd = 1'b0; clear = 1'b0; start = 1'b0; gap = '0;
`ifdef QA_SAMPLE_SOURCE_LOOP_EN
    n_loops = '0;
`endif
    repeat (3) tick();
    check_idle_outputs("reset");
    rst_n = 1'b1;
    tick();

    // 4 samples back-to-back
    load_seq(4);
    check("count_after_load4", 64'(count), 64'd4);
    push_seq(4);
    do_start(0);
    wait_drain(50);
    check_spacing(4, 1);
    check("busy_cycles_gap0", 64'(busy_cycles), 64'd4);
    check("count_retained", 64'(count), 64'd4);

    // Same buffer replayed with gap=2
    push_seq(4);
    do_start(2);
    wait_drain(80);
    check_spacing(4, 3);
    check("busy_cycles_gap2", 64'(busy_cycles), 64'd10);

    // Start with an empty buffer: done only
    pulse_clear();
    check("count_after_clear", 64'(count), 64'd0);
    e.nd = 1'b0; e.data = '0; e.dn = 1'b1;
    exp_q.push_back(e);
    do_start(0);
    @(negedge clk);
    #2;
    check("empty_done_consumed", 64'(exp_q.size()), 64'd0);
    repeat (3) tick();
    check("empty_busy_cycles", 64'(busy_cycles), 64'd0);
    check("empty_no_nd", 64'(nd_stamps.size()), 64'd0);

    // Overflow: 65 loads into 64 entries
    load_seq(65);
    check("count_full", 64'(count), 64'd64);
    check("overflow_set", 64'(overflow), 64'd1);
    push_seq(64);
    do_start(0);
    wait_drain(200);
    check_spacing(64, 1);
    check("overflow_sticky", 64'(overflow), 64'd1);

    // Clear during second gap cycle of a gap=3 playback
    pulse_clear();
    check("overflow_cleared", 64'(overflow), 64'd0);
    load_seq(4);
    e.nd = 1'b1; e.data = WIDTH'(1); e.dn = 1'b0;
    exp_q.push_back(e);
    do_start(3);     // now in the first-sample cycle
    tick();          // first gap cycle
    tick();          // second gap cycle
    pulse_clear();
    repeat (12) tick();
    check("clear_abort_pulses", 64'(nd_stamps.size()), 64'd1);
    check("clear_abort_pending", 64'(exp_q.size()), 64'd0);
    check("clear_abort_count", 64'(count), 64'd0);
    check("clear_abort_busy", 64'(busy), 64'd0);

    // Asynchronous reset in the middle of playback
    load_seq(4);
    push_seq(4);
    do_start(1);
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    check_idle_outputs("async_reset");
    exp_q.delete();
    tick();
    rst_n = 1'b1;
    tick();

`ifdef QA_SAMPLE_SOURCE_LOOP_EN
    // Two passes of 3 samples with gap=1
    load_seq(3);
    for (int p = 0; p < 2; p++)
      for (int i = 0; i < 3; i++) begin
        e.nd = 1'b1; e.data = WIDTH'(i + 1); e.dn = (p == 1 && i == 2);
        exp_q.push_back(e);
      end
    n_loops = 8'd1;
    do_start(1);
    n_loops = 8'd0;
    wait_drain(80);
    check_spacing(6, 2);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
